// File: rtl/crc10_framer.sv
// rtl/crc10_framer.sv - CRC-10 frame trailer generator, bit-serial LFSR, one word per 34 clocks.
module crc10_framer #(
  parameter logic [9:0] CRC_INIT = 10'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [9:0]  crc_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_SEND_D = 2'd2,
    ST_SEND_C = 2'd3
  } state_t;

  state_t      r_state;
  logic [9:0]  r_crc;
  logic [31:0] r_hold_data;
  logic        r_hold_last;
  logic [4:0]  r_bit_cnt;
  logic        r_m_valid;
  logic        r_m_last;
  logic [31:0] r_m_data;

  logic        w_bit;
  logic        w_fb;
  logic [9:0]  w_crc_next;

  // One LFSR step for G(x)=x^10+x^9+x^5+x+1, feedback into taps 0, 1, 5 and 9.
  always_comb begin
    w_bit      = r_hold_data[r_bit_cnt];
    w_fb       = r_crc[9] ^ w_bit;
    w_crc_next = {r_crc[8] ^ w_fb, r_crc[7:5], r_crc[4] ^ w_fb,
                  r_crc[3:1], r_crc[0] ^ w_fb, w_fb};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= CRC_INIT;
      r_hold_data <= 32'h0;
      r_hold_last <= 1'b0;
      r_bit_cnt   <= 5'd0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_hold_data <= s_data;
            r_hold_last <= s_last;
            r_bit_cnt   <= 5'd0;
            r_state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_crc     <= w_crc_next;
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd31) begin
            r_state   <= ST_SEND_D;
            r_m_valid <= 1'b1;
            r_m_data  <= r_hold_data;
            r_m_last  <= 1'b0;
          end
        end
        ST_SEND_D: begin
          if (m_ready) begin
            if (r_hold_last) begin
              r_state  <= ST_SEND_C;
              r_m_data <= {22'b0, r_crc};
              r_m_last <= 1'b1;
            end else begin
              r_state   <= ST_IDLE;
              r_m_valid <= 1'b0;
            end
          end
        end
        ST_SEND_C: begin
          if (m_ready) begin
            r_crc     <= CRC_INIT;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready = (r_state == ST_IDLE);
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_data  = r_m_data;
  assign crc_out = r_crc;

endmodule

// File: tb/tb_crc10_framer.sv
// tb/tb_crc10_framer.sv - randomized self-checking bench for crc10_framer against a polynomial-division model.
module tb_crc10_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [9:0]  crc_out;

  int checks = 0;
  int errors = 0;
  logic [32:0] out_q[$];

  crc10_framer dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  // Transfers are recorded mid-cycle; the handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) out_q.push_back({m_last, m_data});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] model_crc(input logic [31:0] w[$]);
    logic [9:0] c = 10'h000;
    logic       top;
    foreach (w[i]) begin
      for (int b = 0; b < 32; b++) begin
        top = c[9] ^ w[i][b];
        c   = {c[8:0], 1'b0} ^ (top ? 10'h223 : 10'h000);
      end
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    while (!s_ready && n < 500) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout s_ready=%0b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'h0;
  endtask

  task automatic send_frame(input logic [31:0] w[$]);
    foreach (w[i]) send_word(w[i], i == w.size() - 1);
  endtask

  task automatic wait_outputs(input int n);
    int c = 0;
    while (out_q.size() < n && c < 3000) begin
      tick();
      c++;
    end
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL out_timeout got %0d words required %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0; m_ready = 1'b1;
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b required 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %0b required 0", m_last); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data got %h required 0", m_data); end
    checks++; if (crc_out !== 10'h000) begin errors++; $display("FAIL rst_crc got %h required 000", crc_out); end
    rst = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %0b required 1", s_ready); end
  endtask

  task automatic test_single(input logic [31:0] d, input logic [9:0] exp_crc);
    out_q.delete();
    m_ready = 1'b1;
    send_word(d, 1'b1);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL single_calc_ready got %0b required 0", s_ready); end
    repeat (31) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b required 0", m_valid); end
    tick();
    checks++; if ({m_valid, m_last, m_data} !== {2'b10, d}) begin
      errors++; $display("FAIL single_data got v%0b l%0b %h required v1 l0 %h", m_valid, m_last, m_data, d); end
    checks++; if (crc_out !== exp_crc) begin errors++; $display("FAIL single_crc_out got %h required %h", crc_out, exp_crc); end
    tick();
    checks++; if ({m_valid, m_last, m_data} !== {2'b11, 22'b0, exp_crc}) begin
      errors++; $display("FAIL single_trailer got v%0b l%0b %h required v1 l1 %h", m_valid, m_last, m_data, exp_crc); end
    tick();
    checks++; if ({m_valid, s_ready, crc_out} !== {2'b01, 10'h000}) begin
      errors++; $display("FAIL single_done got v%0b r%0b crc %h required v0 r1 crc 000", m_valid, s_ready, crc_out); end
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL single_count got %0d required 2", out_q.size()); end
  endtask

  task automatic test_two_frames();
    logic [31:0] f1[$];
    logic [31:0] f2[$];
    logic [32:0] exp_q[$];
    f1 = '{32'h8000_0000, 32'h0000_0000};
    f2 = '{32'h8000_0000};
    out_q.delete();
    m_ready = 1'b1;
    send_frame(f1);
    send_frame(f2);
    wait_outputs(5);
    exp_q = '{{1'b0, 32'h8000_0000}, {1'b0, 32'h0}, {1'b1, 22'b0, model_crc(f1)},
              {1'b0, 32'h8000_0000}, {1'b1, 32'h0000_0223}};
    checks++; if (out_q.size() !== 5) begin errors++; $display("FAIL two_count got %0d required 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_word%0d got %h required %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] fr[$];
    logic [32:0] exp_q[$];
    exp_q = {};
    out_q.delete();
    m_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(1, 5);
      fr = {};
      for (int k = 0; k < len; k++) fr.push_back($urandom());
      foreach (fr[k]) exp_q.push_back({1'b0, fr[k]});
      exp_q.push_back({1'b1, 22'b0, model_crc(fr)});
      send_frame(fr);
    end
    wait_outputs(exp_q.size());
    checks++; if (out_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d required %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d got %h required %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic        l0;
    logic [9:0]  c0;
    int          n = 0;
    out_q.delete();
    m_ready = 1'b0;
    send_word(32'h4000_0000, 1'b1);
    while (!m_valid && n < 100) begin tick(); n++; end
    for (int ph = 0; ph < 2; ph++) begin
      d0 = m_data; l0 = m_last; c0 = crc_out;
      checks++; if ({l0, d0} !== (ph == 0 ? {1'b0, 32'h4000_0000} : {1'b1, 32'h0000_0265})) begin
        errors++; $display("FAIL bp_phase%0d_word got l%0b %h", ph, l0, d0); end
      for (int k = 0; k < 10; k++) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = $urandom();
        s_last  = 1'b1;
        tick();
        checks++;
        if ({m_valid, m_last, m_data, crc_out, s_ready} !== {1'b1, l0, d0, c0, 1'b0}) begin
          errors++;
          $display("FAIL bp_stable ph%0d cyc%0d got v%0b l%0b %h crc %h r%0b required v1 l%0b %h crc %h r0",
                   ph, k, m_valid, m_last, m_data, crc_out, s_ready, l0, d0, c0);
        end
      end
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    m_ready = 1'b1;
    repeat (40) tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_valid got %0b required 0", m_valid); end
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL bp_count got %0d required 2", out_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_q.delete();
    m_ready = 1'b1;
    send_word(32'h1234_5678, 1'b0);
    send_word(32'hdead_beef, 1'b1);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    checks++; if ({m_valid, m_last, m_data, crc_out} !== 44'h0) begin
      errors++; $display("FAIL mid_rst got v%0b l%0b %h crc %h required all 0", m_valid, m_last, m_data, crc_out); end
    tick();
    rst = 1'b1;
    repeat (50) tick();
    checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL mid_rst_count got %0d required 1", out_q.size()); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %0b required 1", s_ready); end
    send_word(32'h8000_0000, 1'b1);
    wait_outputs(3);
    checks++; if (out_q.size() < 3 || out_q[2] !== {1'b1, 32'h0000_0223}) begin
      errors++; $display("FAIL mid_rst_trailer got %h required 100000223", out_q.size() >= 3 ? out_q[2] : 33'h0); end
  endtask

  initial begin
    test_reset();
    test_single(32'h0000_0000, 10'h000);
    test_single(32'h8000_0000, 10'h223);
    test_single(32'h4000_0000, 10'h265);
    test_two_frames();
    test_random_frames();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
